// File: rtl/upd_llr_pkg.sv
// ----------------------------------------------------------------------------
// upd_llr_pkg
//   Shared definitions for the PHY-to-LLR packer:
//     - llr_state_e      : packer FSM states (IDLE / RUN / FLUSH)
//     - DEF_*            : default widths used by the top-level parameters
//     - re_mask_bit()    : valid-RE mask generator, one mask bit per call
// ----------------------------------------------------------------------------
package upd_llr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } llr_state_e;

   localparam int unsigned DEF_RE_PER_BEAT = 2;
   localparam int unsigned DEF_IQ_W        = 16;
   localparam int unsigned DEF_NOISE_W     = 16;
   localparam int unsigned DEF_CNT_W       = 16;

   // Bit idx of a valid-RE mask holding n_re valid REs in the LSBs.
   function automatic logic re_mask_bit(input logic [3:0] n_re, input int unsigned idx);
      return (idx < {28'd0, n_re});
   endfunction

endpackage

// File: rtl/upd_llr_out_slice.sv
// ----------------------------------------------------------------------------
// upd_llr_out_slice
//   Single-entry output register with valid/ready handshake. A payload is
//   loaded when in_valid meets in_ready and held stable until out_ready.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     clr             : synchronous clear, drops the held beat
//     in_valid/in_data/in_ready : producer side (in_ready combinational)
//     out_valid/out_data/out_ready : consumer side (registered)
// ----------------------------------------------------------------------------
module upd_llr_out_slice #(
   parameter int unsigned PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 in_valid,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [PAYLOAD_W-1:0] out_data,
   input  logic                 out_ready
);

   logic                 valid_r;
   logic [PAYLOAD_W-1:0] data_r;

   // The slot can take a new beat when empty or when the held beat leaves now.
   assign in_ready  = !valid_r || out_ready;
   assign out_valid = valid_r;
   assign out_data  = data_r;

   // Output register: load on handshake, release once the consumer accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         data_r  <= '0;
      end else if (clr) begin
         valid_r <= 1'b0;
         data_r  <= '0;
      end else if (in_valid && in_ready) begin
         valid_r <= 1'b1;
         data_r  <= in_data;
      end else if (out_ready) begin
         valid_r <= 1'b0;
         data_r  <= data_r;
      end else begin
         valid_r <= valid_r;
         data_r  <= data_r;
      end
   end

endmodule

// File: rtl/upd_phy_to_llr_packer.sv
// ----------------------------------------------------------------------------
// upd_phy_to_llr_packer
//   Pops packed IQ words and per-group noise samples from two show-ahead
//   FIFOs and presents them as registered beats of RE_PER_BEAT REs for one
//   user. A noise sample is shared by i_user_iq_noise_rate REs.
//   Optional feature macro: UPD_LLR_PACK_STATS_EN (starvation counter on
//   o_stall_cycles; tied to zero when undefined).
//   Ports:
//     i_core_clk, i_rx_rstn        : clock, asynchronous active-low reset
//     i_start, i_abort             : begin user (IDLE only) / abort user
//     i_user_iq_noise_rate         : REs per noise sample
//     i_cur_user_re_amounts        : REs in this user
//     i_iq_fifo_*, i_noise_fifo_*  : show-ahead FIFO data and empty flags
//     o_iq_fifo_rd_en, o_noise_fifo_rd_en : pop strobes (combinational)
//     i_out_ready, o_data_strobe   : output handshake
//     o_re_data_i/q, o_noise_data, o_re_mask, o_last : beat payload
//     o_done, o_cfg_err            : end-of-user / bad-config pulses
//     o_busy, o_stall_cycles       : status
// ----------------------------------------------------------------------------
module upd_phy_to_llr_packer
   import upd_llr_pkg::*;
#(
   parameter int unsigned RE_PER_BEAT = DEF_RE_PER_BEAT,
   parameter int unsigned IQ_W        = DEF_IQ_W,
   parameter int unsigned NOISE_W     = DEF_NOISE_W,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic                          i_core_clk,
   input  logic                          i_rx_rstn,
   input  logic                          i_start,
   input  logic                          i_abort,
   input  logic [CNT_W-1:0]              i_user_iq_noise_rate,
   input  logic [CNT_W-1:0]              i_cur_user_re_amounts,
   input  logic [RE_PER_BEAT*2*IQ_W-1:0] i_iq_fifo_data,
   input  logic                          i_iq_fifo_empty,
   input  logic                          i_noise_fifo_empty,
   input  logic [NOISE_W-1:0]            i_noise_fifo_data,
   output logic                          o_iq_fifo_rd_en,
   output logic                          o_noise_fifo_rd_en,
   input  logic                          i_out_ready,
   output logic                          o_data_strobe,
   output logic [RE_PER_BEAT*IQ_W-1:0]   o_re_data_i,
   output logic [RE_PER_BEAT*IQ_W-1:0]   o_re_data_q,
   output logic [NOISE_W-1:0]            o_noise_data,
   output logic [RE_PER_BEAT-1:0]        o_re_mask,
   output logic                          o_last,
   output logic                          o_done,
   output logic                          o_cfg_err,
   output logic                          o_busy,
   output logic [31:0]                   o_stall_cycles
);

   localparam int unsigned BEAT_W = RE_PER_BEAT * IQ_W;
   localparam int unsigned PAY_W  = 1 + RE_PER_BEAT + NOISE_W + 2 * BEAT_W;
   localparam logic [CNT_W:0]   RPB_WIDE   = (CNT_W+1)'(RE_PER_BEAT);
   localparam logic [CNT_W-1:0] RPB_NARROW = CNT_W'(RE_PER_BEAT);

   llr_state_e       state_r, state_nxt_s;
   logic [CNT_W-1:0] rate_r, amounts_r;
   logic [CNT_W:0]   re_cnt_r, grp_cnt_r;   // one spare bit so the max user never wraps
   logic             done_r, cfg_err_r;

   logic [CNT_W:0]       rem_s, grp_nxt_s;
   logic                 last_beat_s, grp_done_s, fire_s, slice_ready_s;
   logic                 start_idle_s, cfg_bad_s, run_start_s, cfg_err_s, done_s;
   logic [RE_PER_BEAT-1:0] mask_s;
   logic [BEAT_W-1:0]    iq_i_s, iq_q_s;
   logic [PAY_W-1:0]     pay_s, slice_data_s;

   // Beat datapath: remaining REs, noise-group progress, mask and I/Q split.
   always_comb begin
      rem_s       = {1'b0, amounts_r} - re_cnt_r;
      last_beat_s = (rem_s <= RPB_WIDE);
      grp_nxt_s   = grp_cnt_r + RPB_WIDE;
      grp_done_s  = (grp_nxt_s == {1'b0, rate_r});
      mask_s      = '0;
      iq_i_s      = '0;
      iq_q_s      = '0;
      for (int unsigned k = 0; k < RE_PER_BEAT; k++) begin
         if (last_beat_s) begin
            mask_s[k] = re_mask_bit(rem_s[3:0], k);
         end else begin
            mask_s[k] = 1'b1;
         end
         iq_i_s[k*IQ_W +: IQ_W] = i_iq_fifo_data[(2*k)*IQ_W +: IQ_W];
         iq_q_s[k*IQ_W +: IQ_W] = i_iq_fifo_data[(2*k+1)*IQ_W +: IQ_W];
      end
      pay_s = {last_beat_s, mask_s, i_noise_fifo_data, iq_q_s, iq_i_s};
   end

   assign fire_s = (state_r == ST_RUN) && !i_abort && !i_iq_fifo_empty &&
                   !i_noise_fifo_empty && slice_ready_s;

   assign o_iq_fifo_rd_en    = fire_s;
   assign o_noise_fifo_rd_en = fire_s && (grp_done_s || last_beat_s);

   // FSM next state and start/done qualifiers; abort overrides everything.
   always_comb begin
      state_nxt_s  = state_r;
      cfg_bad_s    = (i_user_iq_noise_rate == '0) ||
                     ((i_user_iq_noise_rate % RPB_NARROW) != '0);
      start_idle_s = (state_r == ST_IDLE) && i_start && !i_abort;
      run_start_s  = start_idle_s && (i_cur_user_re_amounts != '0) && !cfg_bad_s;
      cfg_err_s    = start_idle_s && (i_cur_user_re_amounts != '0) && cfg_bad_s;
      done_s       = (state_r == ST_FLUSH) && slice_ready_s && !i_abort;
      case (state_r)
         ST_IDLE: begin
            if (i_start) begin
               if (i_cur_user_re_amounts == '0) begin
                  state_nxt_s = ST_FLUSH;
               end else if (cfg_bad_s) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (fire_s && last_beat_s) begin
               state_nxt_s = ST_FLUSH;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_FLUSH: begin
            // Leave only once the last beat has left the output register.
            if (slice_ready_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_FLUSH;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      if (i_abort) begin
         state_nxt_s = ST_IDLE;
      end else begin
         state_nxt_s = state_nxt_s;
      end
   end

   // FSM state register.
   always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
      if (!i_rx_rstn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Latched config, RE/noise-group counters and status pulses.
   always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
      if (!i_rx_rstn) begin
         rate_r    <= '0;
         amounts_r <= '0;
         re_cnt_r  <= '0;
         grp_cnt_r <= '0;
         done_r    <= 1'b0;
         cfg_err_r <= 1'b0;
      end else begin
         done_r    <= done_s;
         cfg_err_r <= cfg_err_s;
         if (i_abort) begin
            re_cnt_r  <= '0;
            grp_cnt_r <= '0;
         end else if (run_start_s) begin
            rate_r    <= i_user_iq_noise_rate;
            amounts_r <= i_cur_user_re_amounts;
            re_cnt_r  <= '0;
            grp_cnt_r <= '0;
         end else if (fire_s) begin
            re_cnt_r  <= re_cnt_r + RPB_WIDE;
            grp_cnt_r <= grp_done_s ? '0 : grp_nxt_s;
         end else begin
            re_cnt_r  <= re_cnt_r;
            grp_cnt_r <= grp_cnt_r;
         end
      end
   end

   upd_llr_out_slice #(
      .PAYLOAD_W (PAY_W)
   ) u_out_slice (
      .clk       (i_core_clk),
      .rst_n     (i_rx_rstn),
      .clr       (i_abort),
      .in_valid  (fire_s),
      .in_data   (pay_s),
      .in_ready  (slice_ready_s),
      .out_valid (o_data_strobe),
      .out_data  (slice_data_s),
      .out_ready (i_out_ready)
   );

   assign {o_last, o_re_mask, o_noise_data, o_re_data_q, o_re_data_i} = slice_data_s;
   assign o_done    = done_r;
   assign o_cfg_err = cfg_err_r;
   assign o_busy    = (state_r != ST_IDLE);

`ifdef UPD_LLR_PACK_STATS_EN
   logic [31:0] stall_r;

   // Starvation counter: RUN cycles lost to an empty FIFO, held at all-ones.
   always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
      if (!i_rx_rstn) begin
         stall_r <= 32'd0;
      end else if (start_idle_s) begin
         stall_r <= 32'd0;
      end else if ((state_r == ST_RUN) && !i_abort &&
                   (i_iq_fifo_empty || i_noise_fifo_empty) &&
                   (stall_r != 32'hFFFF_FFFF)) begin
         stall_r <= stall_r + 32'd1;
      end else begin
         stall_r <= stall_r;
      end
   end

   assign o_stall_cycles = stall_r;
`else
   assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_upd_phy_to_llr_packer.sv
// ----------------------------------------------------------------------------
// tb_upd_phy_to_llr_packer
//   Directed bench for upd_phy_to_llr_packer (RE_PER_BEAT=2, 16-bit samples).
//   IQ FIFO word n carries I = 2n+k, Q = I ^ 0x8000 for RE k; noise word n
//   carries 0x5000 + n. Beats are compared against those closed forms.
// ----------------------------------------------------------------------------
module tb_upd_phy_to_llr_packer;

   localparam int RPB = 2;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, iq_empty, noise_empty, ready;
   logic [15:0] rate, amounts, noise_data, noise_o;
   logic [63:0] iq_data;
   logic        iq_rd, noise_rd, strobe, last, done, cfg_err, busy;
   logic [31:0] re_i, re_q, stall;
   logic [1:0]  mask;

   int n_tests = 0;
   int n_fail  = 0;

   int unsigned iq_idx = 0, noise_idx = 0, iq_base = 0, noise_base = 0;
   int unsigned cur_amt = 0, cur_rate = 0;
   int n_acc = 0, iq_pops = 0, noise_pops = 0, done_cnt = 0, cfg_cnt = 0, last_cnt = 0, last_idx = 0;
   logic [1:0]  last_mask = 2'b00;
   logic        prev_strobe = 1'b0, prev_ready = 1'b0;
   logic [82:0] prev_pay = '0;
   int snap_a, snap_b, snap_c;

   always #5 clk = ~clk;

   upd_phy_to_llr_packer dut (
      .i_core_clk            (clk),
      .i_rx_rstn             (rst_n),
      .i_start               (start),
      .i_abort               (abort),
      .i_user_iq_noise_rate  (rate),
      .i_cur_user_re_amounts (amounts),
      .i_iq_fifo_data        (iq_data),
      .i_iq_fifo_empty       (iq_empty),
      .i_noise_fifo_empty    (noise_empty),
      .i_noise_fifo_data     (noise_data),
      .o_iq_fifo_rd_en       (iq_rd),
      .o_noise_fifo_rd_en    (noise_rd),
      .i_out_ready           (ready),
      .o_data_strobe         (strobe),
      .o_re_data_i           (re_i),
      .o_re_data_q           (re_q),
      .o_noise_data          (noise_o),
      .o_re_mask             (mask),
      .o_last                (last),
      .o_done                (done),
      .o_cfg_err             (cfg_err),
      .o_busy                (busy),
      .o_stall_cycles        (stall)
   );

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] iq_i(input int unsigned idx, input int unsigned k);
      return 16'(idx * 2 + k);
   endfunction

   // Show-ahead FIFO sources.
   always_comb begin
      iq_data = '0;
      for (int k = 0; k < RPB; k++) begin
         iq_data[(2*k)*16 +: 16]   = iq_i(iq_idx, k);
         iq_data[(2*k+1)*16 +: 16] = iq_i(iq_idx, k) ^ 16'h8000;
      end
      noise_data = 16'(noise_idx) + 16'h5000;
   end

   always @(posedge clk) begin
      if (iq_rd)    iq_idx    <= iq_idx + 1;
      if (noise_rd) noise_idx <= noise_idx + 1;
   end

   // Output monitor: pops, pulses, beat contents and hold-under-backpressure.
   always @(negedge clk) begin
      if (rst_n) begin
         if (iq_rd)    iq_pops    <= iq_pops + 1;
         if (noise_rd) noise_pops <= noise_pops + 1;
         if (done)     done_cnt   <= done_cnt + 1;
         if (cfg_err)  cfg_cnt    <= cfg_cnt + 1;
         if (strobe && prev_strobe && !prev_ready)
            check_eq("hold", {last, mask, noise_o, re_q, re_i}, prev_pay);
         if (strobe && ready) begin : beat_chk
            int unsigned b, nb;
            logic        e_last;
            logic [1:0]  e_mask;
            logic [15:0] e_noise;
            b       = n_acc;
            nb      = (cur_amt + 1) / 2;
            e_last  = (b == nb - 1);
            e_mask  = (e_last && (cur_amt % 2 == 1)) ? 2'b01 : 2'b11;
            e_noise = 16'(noise_base + ((cur_rate == 0) ? 0 : (b * 2) / cur_rate)) + 16'h5000;
            check_eq("beat", {last, mask, noise_o, re_q, re_i},
                     {e_last, e_mask, e_noise,
                      iq_i(iq_base + b, 1) ^ 16'h8000, iq_i(iq_base + b, 0) ^ 16'h8000,
                      iq_i(iq_base + b, 1), iq_i(iq_base + b, 0)});
            if (last) begin
               last_cnt  <= last_cnt + 1;
               last_mask <= mask;
               last_idx  <= n_acc + 1;
            end
            n_acc <= n_acc + 1;
         end
         prev_strobe <= strobe;
         prev_ready  <= ready;
         prev_pay    <= {last, mask, noise_o, re_q, re_i};
      end else begin
         prev_strobe <= 1'b0;
      end
   end

   task automatic start_user(input logic [15:0] amt, input logic [15:0] rt);
      @(posedge clk); #1;
      amounts    = amt;
      rate       = rt;
      start      = 1'b1;
      iq_base    = iq_idx;
      noise_base = noise_idx;
      cur_amt    = amt;
      cur_rate   = rt;
      n_acc = 0; iq_pops = 0; noise_pops = 0; done_cnt = 0; cfg_cnt = 0; last_cnt = 0; last_idx = 0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check_eq(tag, seen, 1'b1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_beats(input int n, input string tag);
      for (int i = 0; i < 5000 && n_acc < n; i++) @(negedge clk);
      check_eq(tag, (n_acc >= n), 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
      iq_empty = 1'b0; noise_empty = 1'b0; rate = 16'd0; amounts = 16'd0;
      repeat (3) @(negedge clk);
      check_eq("reset_ctrl", {strobe, busy, iq_rd, noise_rd, done, cfg_err, last, mask}, 9'd0);
      check_eq("reset_data", {re_i, re_q, noise_o, stall}, 112'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("idle_after_reset", {busy, iq_rd, strobe}, 3'd0);

      // Full user.
      start_user(16'd1800, 16'd6);
      wait_done(2000, "full_done");
      check_eq("full_beats", n_acc, 900);
      check_eq("full_iq_pops", iq_pops, 900);
      check_eq("full_noise_pops", noise_pops, 300);
      check_eq("full_last", {last_cnt, last_idx}, {32'd1, 32'd900});
      check_eq("full_done_cnt", done_cnt, 1);
      check_eq("full_idle", busy, 1'b0);

      // Partial last beat.
      start_user(16'd7, 16'd6);
      wait_done(50, "part_done");
      check_eq("part_beats", n_acc, 4);
      check_eq("part_noise_pops", noise_pops, 2);
      check_eq("part_last_mask", last_mask, 2'b01);

      // IQ starvation mid-user.
      start_user(16'd1800, 16'd6);
      wait_beats(100, "starve_reach");
      @(posedge clk); #1 iq_empty = 1'b1;
      snap_a = iq_pops + noise_pops;
      @(posedge clk); #1;
      snap_b = n_acc;
      repeat (38) @(posedge clk);
      #1 iq_empty = 1'b0;
      check_eq("starve_pops", iq_pops + noise_pops - snap_a, 0);
      check_eq("starve_strobes", n_acc - snap_b, 0);
      wait_done(2000, "starve_done");
      check_eq("starve_beats", n_acc, 900);
      check_eq("starve_noise_pops", noise_pops, 300);
`ifdef UPD_LLR_PACK_STATS_EN
      check_eq("stall_cycles", stall, 32'd39);
`else
      check_eq("stall_tied0", stall, 32'd0);
`endif

      // Backpressure.
      start_user(16'd100, 16'd6);
      wait_beats(20, "bp_reach");
      @(posedge clk); #1 ready = 1'b0;
      snap_a = iq_pops + noise_pops;
      snap_c = n_acc;
      repeat (10) @(posedge clk);
      check_eq("bp_strobe_held", strobe, 1'b1);
      #1 ready = 1'b1;
      check_eq("bp_pops", iq_pops + noise_pops - snap_a, 0);
      check_eq("bp_no_accept", n_acc - snap_c, 0);
      wait_done(200, "bp_done");
      check_eq("bp_beats", n_acc, 50);
      check_eq("bp_noise_pops", noise_pops, 17);

      // Config errors.
      start_user(16'd10, 16'd3);
      repeat (3) @(negedge clk);
      check_eq("cfg_err_rate3", {cfg_cnt, iq_pops, noise_pops}, {32'd1, 32'd0, 32'd0});
      check_eq("cfg_err_idle", busy, 1'b0);
      start_user(16'd10, 16'd0);
      repeat (3) @(negedge clk);
      check_eq("cfg_err_rate0", {cfg_cnt, iq_pops}, {32'd1, 32'd0});

      // Zero-RE user.
      start_user(16'd0, 16'd6);
      @(negedge clk);
      check_eq("zero_flush", {busy, done}, 2'b10);
      @(negedge clk);
      check_eq("zero_done", {busy, done}, 2'b01);
      repeat (3) @(negedge clk);
      check_eq("zero_pops", {cfg_cnt, iq_pops, noise_pops, done_cnt}, {32'd0, 32'd0, 32'd0, 32'd1});

      // Abort at beat 100.
      start_user(16'd1800, 16'd6);
      wait_beats(100, "abort_reach");
      @(posedge clk); #1 abort = 1'b1;
      @(negedge clk);
      check_eq("abort_no_pop", {iq_rd, noise_rd}, 2'b00);
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check_eq("abort_clear", {strobe, busy}, 2'b00);
      repeat (20) @(negedge clk);
      check_eq("abort_no_done", {done_cnt, 31'd0, strobe}, 64'd0);

      // Reset mid-user.
      start_user(16'd1800, 16'd6);
      wait_beats(50, "rst_reach");
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      check_eq("rst_mid_ctrl", {strobe, busy, iq_rd, noise_rd, done, cfg_err, last, mask}, 9'd0);
      check_eq("rst_mid_data", {re_i, re_q, noise_o, stall}, 112'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("rst_wait_start", {busy, strobe, iq_rd}, 3'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/upd_phy_to_llr_packer.md
UPD_PHY_TO_LLR_PACKER -- requirements
Module: upd_phy_to_llr_packer

Interface
REQ-001 Parameter RE_PER_BEAT, default 2, REs packed per output beat (1..8).
REQ-002 Parameter IQ_W, default 16, width of each I and Q sample.
REQ-003 Parameter NOISE_W, default 16, width of each noise sample.
REQ-004 Parameter CNT_W, default 16, width of the RE counts and of the rate.
REQ-005 i_core_clk  in  1  single clock; all logic on its rising edge.
REQ-006 i_rx_rstn  in  1  reset, asynchronous and active-low.
REQ-007 i_start  in  1  one-cycle pulse; latches the config and begins a user.
REQ-008 i_abort  in  1  synchronous abort of the current user.
REQ-009 i_user_iq_noise_rate  in  CNT_W  REs sharing one noise sample.
REQ-010 i_cur_user_re_amounts  in  CNT_W  REs for this user.
REQ-011 i_iq_fifo_data  in  RE_PER_BEAT*2*IQ_W  show-ahead IQ word; RE k occupies I then Q, RE0 in the LSBs.
REQ-012 i_iq_fifo_empty / i_noise_fifo_empty  in  1 each  FIFO empty flags.
REQ-013 i_noise_fifo_data  in  NOISE_W  show-ahead noise word.
REQ-014 o_iq_fifo_rd_en / o_noise_fifo_rd_en  out  1 each  pop strobes, combinational.
REQ-015 i_out_ready  in  1  downstream accept.
REQ-016 o_data_strobe  out  1  output beat valid.
REQ-017 o_re_data_i / o_re_data_q  out  RE_PER_BEAT*IQ_W each  packed I and Q.
REQ-018 o_noise_data  out  NOISE_W  noise sample for this beat.
REQ-019 o_re_mask  out  RE_PER_BEAT  valid-RE mask.
REQ-020 o_last / o_done / o_cfg_err  out  1 each  last beat / end-of-user pulse / config error pulse.
REQ-021 o_busy  out  1  high while not IDLE.
REQ-022 o_stall_cycles  out  32  stall counter (see Configuration).

Function
REQ-023 FSM states: IDLE, RUN and FLUSH; i_start is ignored outside IDLE.
REQ-024 IDLE to FLUSH: taken on i_start when amounts=0; no pops occur.
REQ-025 IDLE, config error: taken on i_start when rate=0 or rate mod RE_PER_BEAT≠0; o_cfg_err pulses one cycle and the FSM stays in IDLE.
REQ-026 IDLE to RUN: taken on i_start otherwise; the config is latched and the counters are cleared.
REQ-027 fire = RUN & !iq_empty & !noise_empty & (!o_data_strobe | i_out_ready).
REQ-028 On fire: o_iq_fifo_rd_en=1 in the same cycle.
REQ-029 On fire, the noise pop: o_noise_fifo_rd_en=1 when the beat completes a noise group (REs consumed reach a multiple of rate) or the beat is last.
REQ-030 Output latency: registered outputs load on the cycle after fire.
REQ-031 Strobe hold: o_data_strobe and its data hold until i_out_ready=1.
REQ-032 Last beat: the beat whose REs reach amounts; its mask has (amounts-1) mod RE_PER_BEAT + 1 LSBs set, and all other beats have an all-ones mask.
REQ-033 After the last beat fires, the FSM moves RUN to FLUSH; FLUSH waits until the last beat is accepted, then pulses o_done and returns to IDLE.
REQ-034 With amounts=0, o_done pulses one cycle after FLUSH is entered.
REQ-035 Empty FIFO: an empty FIFO stalls the beat; there is no pop and no output change.
REQ-036 Pending beat: any beat already on the outputs still completes.
REQ-037 i_abort has priority over everything; it clears o_data_strobe and the counters, gives no o_done, and returns the FSM to IDLE next cycle.
REQ-038 Counters saturate-free: the RE counter has CNT_W+1 bits, so amounts=2^CNT_W-1 does not wrap.

Reset
REQ-039 Asserting i_rx_rstn forces IDLE and zeroes every registered output, counter and o_stall_cycles, including mid-user.
REQ-040 Both rd_en outputs are 0 during reset.
REQ-041 After release, the block waits for a fresh i_start.

Configuration
REQ-042 With UPD_LLR_PACK_STATS_EN defined, o_stall_cycles counts RUN cycles with no fire caused by an empty FIFO; it is cleared on i_start and does not wrap past all-ones.
REQ-043 Without UPD_LLR_PACK_STATS_EN, o_stall_cycles is tied to 0 and no counter logic exists.

Structure
REQ-044 Package upd_llr_pkg holds the FSM state enum, the default widths and a mask-generation function.
REQ-045 The output register slice is sub-module upd_llr_out_slice, parameterised by payload width, with valid/ready and hold behaviour.

Verification
REQ-046 Full user: RE_PER_BEAT=2, amounts=1800, rate=6, FIFOs never empty, ready=1 -> 900 strobes, 300 noise pops, o_last on strobe 900, one o_done.
REQ-047 Partial last beat: amounts=7, rate=6 -> 4 beats, last mask 2'b01, 2 noise pops (on beats 3 and 4).
REQ-048 Starvation: IQ empty for 39 cycles mid-user -> no pops and no new strobes; with STATS_EN, o_stall_cycles=39; the user completes with 900 beats.
REQ-049 Backpressure: ready=0 for 10 cycles -> strobe and data are held stable, no pops, and no beat is lost or duplicated.
REQ-050 Config error: rate=3, RE_PER_BEAT=2 -> one o_cfg_err pulse, no pops, o_busy=0; amounts=0 -> o_done one cycle after FLUSH, no pops.
REQ-051 Abort and reset: i_abort at beat 100 -> strobe=0 next cycle and no o_done; i_rx_rstn low mid-user -> all outputs 0.
